trap_ctrl: RTL and testbench

- Consumes the prioritised trap request (trap_en/cause/epc/val) from the trap-priority stage and commits it architecturally.
- Owns the trap CSRs, the current privilege level, and mret/sret return handling.
- Produces a registered pipeline redirect (PC plus valid pulse).
- Feeds prv_cur/tvm/tsr back to the trap-priority stage and to decode.

---
 rtl/cpu_define.sv | 55 +++++
 rtl/trap_ctrl_status.sv | 70 +++++++
 rtl/trap_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_trap_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_define.sv
// Shared privilege, CSR address, mstatus layout and cause-code definitions
// used by the trap controller and its status sub-block.
package cpu_define;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_H = 2'b10;
  localparam logic [1:0] PRV_M = 2'b11;

  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_STVEC   = 12'h105;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEDELEG = 12'h302;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_SIE    = 1;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_SPIE   = 5;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_SPP    = 8;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_TVM    = 20;
  localparam int MSTATUS_TSR    = 22;

  localparam int CAUSE_MISALIGNED_FETCH = 0;
  localparam int CAUSE_ILLEGAL_INSN     = 2;
  localparam int CAUSE_BREAKPOINT       = 3;
  localparam int CAUSE_ECALL_U          = 8;
  localparam int CAUSE_ECALL_S          = 9;
  localparam int CAUSE_ECALL_M          = 11;

  typedef struct packed {
    logic       tsr;
    logic       tvm;
    logic [1:0] mpp;
    logic       spp;
    logic       mpie;
    logic       spie;
    logic       mie;
    logic       sie;
  } mstatus_t;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } redir_state_e;

endpackage

// File: rtl/trap_ctrl_status.sv
// mstatus fields and current privilege, with trap entry / xret update rules.
// Event inputs are mutually exclusive; an event overrides a same-cycle CSR write per field.
module trap_ctrl_status
  import cpu_define::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       trap_m_i,
  input  logic       trap_s_i,
  input  logic       mret_i,
  input  logic       sret_i,
  input  logic       wr_mstatus_i,
  input  logic       wr_sstatus_i,
  input  mstatus_t   wfields_i,
  output mstatus_t   st_o,
  output logic [1:0] prv_o
);

  mstatus_t   st_q, st_d;
  logic [1:0] prv_q, prv_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q  <= '0;
      prv_q <= PRV_M;
    end else begin
      st_q  <= st_d;
      prv_q <= prv_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    prv_d = prv_q;

    if (wr_mstatus_i) begin
      st_d = wfields_i;
    end else if (wr_sstatus_i) begin
      st_d.sie  = wfields_i.sie;
      st_d.spie = wfields_i.spie;
      st_d.spp  = wfields_i.spp;
    end

    if (trap_m_i) begin
      st_d.mpie = st_q.mie;
      st_d.mie  = 1'b0;
      st_d.mpp  = prv_q;
      prv_d     = PRV_M;
    end else if (trap_s_i) begin
      st_d.spie = st_q.sie;
      st_d.sie  = 1'b0;
      st_d.spp  = prv_q[0];
      prv_d     = PRV_S;
    end else if (mret_i) begin
      prv_d     = st_q.mpp;
      st_d.mie  = st_q.mpie;
      st_d.mpie = 1'b1;
      st_d.mpp  = PRV_U;
    end else if (sret_i) begin
      prv_d     = {1'b0, st_q.spp};
      st_d.sie  = st_q.spie;
      st_d.spie = 1'b1;
      st_d.spp  = 1'b0;
    end
  end

  assign st_o  = st_q;
  assign prv_o = prv_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap commit, trap CSRs, privilege tracking and registered pipeline redirect.
//   state       | meaning
//   ST_IDLE     | accepting traps / mret / sret
//   ST_REDIRECT | redirect pulse out; new requests ignored while the pipe flushes
module trap_ctrl
  import cpu_define::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_epc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  input  logic            sret,
  input  logic            csr_wr,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic [1:0]      prv_cur,
  output logic            tvm,
  output logic            tsr,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  redir_state_e    state_q, state_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] medeleg_q, medeleg_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] stvec_q, stvec_d, sepc_q, sepc_d, scause_q, scause_d, stval_q, stval_d;

  logic            trap_acc, deleg, trap_m, trap_s, mret_acc, sret_acc;
  mstatus_t        st, wfields;
  logic [XLEN-1:0] mstatus, sstatus;

  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = redirect_pc_q;

  assign trap_acc = trap_en && !redirect_valid;
  assign deleg    = (prv_cur != PRV_M) && medeleg_q[trap_cause[4:0]];
  assign trap_m   = trap_acc && !deleg;
  assign trap_s   = trap_acc && deleg;
  assign mret_acc = mret && !trap_acc && !redirect_valid;
  assign sret_acc = sret && !trap_acc && !mret_acc && !redirect_valid;

  always_comb begin
    wfields.sie  = csr_wdata[MSTATUS_SIE];
    wfields.mie  = csr_wdata[MSTATUS_MIE];
    wfields.spie = csr_wdata[MSTATUS_SPIE];
    wfields.mpie = csr_wdata[MSTATUS_MPIE];
    wfields.spp  = csr_wdata[MSTATUS_SPP];
    wfields.mpp  = csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
    wfields.tvm  = csr_wdata[MSTATUS_TVM];
    wfields.tsr  = csr_wdata[MSTATUS_TSR];
  end

  trap_ctrl_status u_status (
    .clk          (clk),
    .rstn         (rstn),
    .trap_m_i     (trap_m),
    .trap_s_i     (trap_s),
    .mret_i       (mret_acc),
    .sret_i       (sret_acc),
    .wr_mstatus_i (csr_wr && (csr_addr == CSR_MSTATUS)),
    .wr_sstatus_i (csr_wr && (csr_addr == CSR_SSTATUS)),
    .wfields_i    (wfields),
    .st_o         (st),
    .prv_o        (prv_cur)
  );

  always_comb begin
    mstatus                                = '0;
    mstatus[MSTATUS_SIE]                   = st.sie;
    mstatus[MSTATUS_MIE]                   = st.mie;
    mstatus[MSTATUS_SPIE]                  = st.spie;
    mstatus[MSTATUS_MPIE]                  = st.mpie;
    mstatus[MSTATUS_SPP]                   = st.spp;
    mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = st.mpp;
    mstatus[MSTATUS_TVM]                   = st.tvm;
    mstatus[MSTATUS_TSR]                   = st.tsr;
    sstatus                                = '0;
    sstatus[MSTATUS_SIE]                   = st.sie;
    sstatus[MSTATUS_SPIE]                  = st.spie;
    sstatus[MSTATUS_SPP]                   = st.spp;
  end

  assign tvm = st.tvm;
  assign tsr = st.tsr;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus;
      CSR_MEDELEG: csr_rdata = medeleg_q;
      CSR_MTVEC:   csr_rdata = mtvec_q;
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = mcause_q;
      CSR_MTVAL:   csr_rdata = mtval_q;
      CSR_SSTATUS: csr_rdata = sstatus;
      CSR_STVEC:   csr_rdata = stvec_q;
      CSR_SEPC:    csr_rdata = sepc_q;
      CSR_SCAUSE:  csr_rdata = scause_q;
      CSR_STVAL:   csr_rdata = stval_q;
      default:     csr_rdata = '0;
    endcase
  end

  // CSR writes first; trap capture then overrides the registers it owns.
  always_comb begin
    medeleg_d = medeleg_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mtval_d   = mtval_q;
    stvec_d   = stvec_q;
    sepc_d    = sepc_q;
    scause_d  = scause_q;
    stval_d   = stval_q;

    if (csr_wr) begin
      case (csr_addr)
        CSR_MEDELEG: begin
          medeleg_d                = csr_wdata;
          medeleg_d[CAUSE_ECALL_M] = 1'b0;
        end
        CSR_MTVEC:  mtvec_d  = csr_wdata;
        CSR_MEPC:   mepc_d   = {csr_wdata[XLEN-1:1], 1'b0};
        CSR_MCAUSE: mcause_d = csr_wdata;
        CSR_MTVAL:  mtval_d  = csr_wdata;
        CSR_STVEC:  stvec_d  = csr_wdata;
        CSR_SEPC:   sepc_d   = {csr_wdata[XLEN-1:1], 1'b0};
        CSR_SCAUSE: scause_d = csr_wdata;
        CSR_STVAL:  stval_d  = csr_wdata;
        default: ;
      endcase
    end

    if (trap_m) begin
      mepc_d   = {trap_epc[XLEN-1:1], 1'b0};
      mcause_d = trap_cause;
      mtval_d  = trap_val;
    end else if (trap_s) begin
      sepc_d   = {trap_epc[XLEN-1:1], 1'b0};
      scause_d = trap_cause;
      stval_d  = trap_val;
    end
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE:     if (trap_acc || mret_acc || sret_acc) state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (trap_m)        redirect_pc_d = {mtvec_q[XLEN-1:2], 2'b00};
    else if (trap_s)   redirect_pc_d = {stvec_q[XLEN-1:2], 2'b00};
    else if (mret_acc) redirect_pc_d = mepc_q;
    else if (sret_acc) redirect_pc_d = sepc_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
      medeleg_q     <= '0;
      mtvec_q       <= RESET_MTVEC;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      stvec_q       <= '0;
      sepc_q        <= '0;
      scause_q      <= '0;
      stval_q       <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      medeleg_q     <= medeleg_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      stvec_q       <= stvec_d;
      sepc_q        <= sepc_d;
      scause_q      <= scause_d;
      stval_q       <= stval_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed plus random stimulus for trap_ctrl against a CSR-map reference model.
`timescale 1ns/1ps
module tb_trap_ctrl;

  localparam logic [31:0] RST_TVEC = 32'h0000_4000;
  localparam logic [31:0] MST_MASK = 32'h0050_19AA;
  localparam logic [31:0] SST_MASK = 32'h0000_0122;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        trap_en = 1'b0, mret = 1'b0, sret = 1'b0, csr_wr = 1'b0;
  logic [31:0] trap_cause = '0, trap_epc = '0, trap_val = '0, csr_wdata = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_rdata, redirect_pc;
  logic [1:0]  prv_cur;
  logic        tvm, tsr, redirect_valid;

  trap_ctrl #(.XLEN(32), .RESET_MTVEC(RST_TVEC)) dut (
    .clk(clk), .rstn(rstn), .trap_en(trap_en), .trap_cause(trap_cause),
    .trap_epc(trap_epc), .trap_val(trap_val), .mret(mret), .sret(sret),
    .csr_wr(csr_wr), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .prv_cur(prv_cur), .tvm(tvm), .tsr(tsr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #20 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: architectural CSR map indexed by address
  logic [31:0] m_csr [0:4095];
  logic [1:0]  m_prv;
  logic        m_busy;
  logic [31:0] m_rpc;

  logic [11:0] rd_list [12] = '{12'h300, 12'h302, 12'h305, 12'h341, 12'h342, 12'h343,
                                12'h100, 12'h105, 12'h141, 12'h142, 12'h143, 12'h344};
  logic [11:0] wr_list [13] = '{12'h300, 12'h302, 12'h305, 12'h341, 12'h342, 12'h343,
                                12'h100, 12'h105, 12'h141, 12'h142, 12'h143, 12'h344, 12'h304};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) m_csr[i] = '0;
    m_csr[12'h305] = RST_TVEC;
    m_prv  = 2'b11;
    m_busy = 1'b0;
    m_rpc  = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h100) return m_csr[12'h300] & SST_MASK;
    return m_csr[a];
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] wd);
    case (a)
      12'h300: m_csr[a] = wd & MST_MASK;
      12'h100: m_csr[12'h300] = (m_csr[12'h300] & ~SST_MASK) | (wd & SST_MASK);
      12'h302: m_csr[a] = wd & ~32'h0000_0800;
      12'h341, 12'h141: m_csr[a] = wd & ~32'h1;
      12'h305, 12'h342, 12'h343, 12'h105, 12'h142, 12'h143: m_csr[a] = wd;
      default: ;
    endcase
  endtask

  task automatic model_step(input logic te, input logic [31:0] tc, tepc, tval,
                            input logic mr, sr, wr, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] ms_old, ms, mtvec_o, stvec_o, mepc_o, sepc_o, tgt;
    logic [1:0]  p_old;
    logic        tacc, macc, sacc, deleg;
    ms_old  = m_csr[12'h300];
    p_old   = m_prv;
    mtvec_o = m_csr[12'h305];
    stvec_o = m_csr[12'h105];
    mepc_o  = m_csr[12'h341];
    sepc_o  = m_csr[12'h141];
    tacc    = te && !m_busy;
    macc    = mr && !tacc && !m_busy;
    sacc    = sr && !tacc && !macc && !m_busy;
    deleg   = (p_old != 2'b11) && m_csr[12'h302][tc[4:0]];
    tgt     = m_rpc;
    if (wr) model_write(a, wd);
    ms = m_csr[12'h300];
    if (tacc && !deleg) begin
      m_csr[12'h341] = tepc & ~32'h1;
      m_csr[12'h342] = tc;
      m_csr[12'h343] = tval;
      ms[7] = ms_old[3]; ms[3] = 1'b0; ms[12:11] = p_old;
      m_prv = 2'b11;
      tgt   = mtvec_o & ~32'h3;
    end else if (tacc) begin
      m_csr[12'h141] = tepc & ~32'h1;
      m_csr[12'h142] = tc;
      m_csr[12'h143] = tval;
      ms[5] = ms_old[1]; ms[1] = 1'b0; ms[8] = p_old[0];
      m_prv = 2'b01;
      tgt   = stvec_o & ~32'h3;
    end else if (macc) begin
      m_prv = ms_old[12:11];
      ms[3] = ms_old[7]; ms[7] = 1'b1; ms[12:11] = 2'b00;
      tgt   = mepc_o;
    end else if (sacc) begin
      m_prv = {1'b0, ms_old[8]};
      ms[1] = ms_old[5]; ms[5] = 1'b1; ms[8] = 1'b0;
      tgt   = sepc_o;
    end
    m_csr[12'h300] = ms;
    m_busy = tacc || macc || sacc;
    m_rpc  = tgt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/rv"}, {31'd0, redirect_valid}, {31'd0, m_busy});
    if (m_busy) chk({tag, "/rpc"}, redirect_pc, m_rpc);
    chk({tag, "/prv"}, {30'd0, prv_cur}, {30'd0, m_prv});
    chk({tag, "/tvm"}, {31'd0, tvm}, {31'd0, m_csr[12'h300][20]});
    chk({tag, "/tsr"}, {31'd0, tsr}, {31'd0, m_csr[12'h300][22]});
    for (int i = 0; i < 12; i++) begin
      csr_addr = rd_list[i];
      #1;
      chk($sformatf("%s/csr%03h", tag, rd_list[i]), csr_rdata, model_read(rd_list[i]));
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    csr_addr = a;
    #1;
    v = csr_rdata;
  endtask

  task automatic step(input string tag, input logic te, input logic [31:0] tc, tepc, tval,
                      input logic mr, sr, wr, input logic [11:0] a, input logic [31:0] wd);
    trap_en = te; trap_cause = tc; trap_epc = tepc; trap_val = tval;
    mret = mr; sret = sr; csr_wr = wr; csr_addr = a; csr_wdata = wd;
    model_step(te, tc, tepc, tval, mr, sr, wr, a, wd);
    @(posedge clk);
    #1;
    trap_en = 1'b0; mret = 1'b0; sret = 1'b0; csr_wr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] v;
    model_reset();
    #30;
    check_all("reset");
    chk("reset/rpc", redirect_pc, 32'h0);
    rstn = 1'b1;

    step("t1", 1, 2, 32'h100, 32'h13, 0, 0, 0, 0, 0);
    chk("t1/pc_lit", redirect_pc, RST_TVEC);
    rd(12'h341, v); chk("t1/mepc_lit", v, 32'h100);
    rd(12'h342, v); chk("t1/mcause_lit", v, 32'h2);
    step("t1_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step("wr_medeleg", 0, 0, 0, 0, 0, 0, 1, 12'h302, 32'h100);
    step("wr_stvec", 0, 0, 0, 0, 0, 0, 1, 12'h105, 32'h8001);
    step("wr_mst0", 0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h0);
    step("mret_u", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step("mret_u_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("u/prv_lit", {30'd0, prv_cur}, 32'h0);
    step("t_deleg", 1, 8, 32'h2000, 32'h55, 0, 0, 0, 0, 0);
    chk("t_deleg/pc_lit", redirect_pc, 32'h8000);
    chk("t_deleg/prv_lit", {30'd0, prv_cur}, 32'h1);
    step("t_deleg_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step("t_to_m", 1, 2, 32'h2100, 0, 0, 0, 0, 0, 0);
    step("t_to_m_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t_nodeleg", 1, 8, 32'h2200, 32'h9, 0, 0, 0, 0, 0);
    rd(12'h342, v); chk("t_nodeleg/mcause_lit", v, 32'h8);
    step("t_nodeleg_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step("wr_mepc", 0, 0, 0, 0, 0, 0, 1, 12'h341, 32'h404);
    step("wr_mst_mpie", 0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h80);
    step("mret", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("mret/pc_lit", redirect_pc, 32'h404);
    step("mret_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("wr_sepc", 0, 0, 0, 0, 0, 0, 1, 12'h141, 32'h606);
    step("wr_mst_spp", 0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h100);
    step("sret", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("sret/pc_lit", redirect_pc, 32'h606);
    chk("sret/prv_lit", {30'd0, prv_cur}, 32'h1);
    step("sret_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step("collide", 1, 5, 32'h3000, 32'h7, 1, 0, 1, 12'h341, 32'hFFF0);
    rd(12'h341, v); chk("collide/mepc_lit", v, 32'h3000);
    step("trap_in_redir", 1, 8, 32'h5000, 32'h1, 0, 0, 0, 0, 0);
    step("post_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step("pre_rst", 1, 3, 32'h7000, 32'h2, 0, 0, 1, 12'h305, 32'h1234_5679);
    rstn = 1'b0;
    #1;
    chk("rst_mid/rv", {31'd0, redirect_valid}, 32'h0);
    chk("rst_mid/prv", {30'd0, prv_cur}, 32'h3);
    rd(12'h305, v); chk("rst_mid/mtvec", v, RST_TVEC);
    model_reset();
    check_all("rst_mid");
    rstn = 1'b1;
    step("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i),
           $urandom_range(0, 9) < 3, 32'($urandom_range(0, 15)), $urandom, $urandom,
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 5,
           wr_list[$urandom_range(0, 12)], $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
